// File: rtl/dbg_seg_display.sv
// Debug-field viewer for the Basys 3 4-digit 7-segment display; a debounced button cycles fields.
// Define DBG_SEG_BLANK_EN to blank leading-zero digits (digit 0 is always lit).
module dbg_seg_display #(
  parameter int unsigned REFRESH_DIV     = 100000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_next,
  input  logic [2:0]  state_dbg,
  input  logic [7:0]  pc_dbg,
  input  logic [15:0] ir_dbg,
  input  logic [15:0] rs_val_dbg,
  input  logic [15:0] rt_val_dbg,
  input  logic [15:0] alu_out_dbg,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic [2:0]  sel_dbg
);

  localparam int unsigned REF_W = $clog2(REFRESH_DIV);
  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    DB_IDLE,
    DB_PRESS_CHK,
    DB_HELD,
    DB_REL_CHK
  } db_state_e;

  logic [1:0]       sync_q;
  db_state_e        db_state_q;
  logic [DB_W-1:0]  db_cnt_q;
  logic [DB_W-1:0]  db_cnt_inc;
  logic             press_q;
  logic             btn_sync;

  logic [REF_W-1:0] ref_q, ref_d;
  logic [1:0]       idx_q, idx_d;
  logic [2:0]       sel_q, sel_d;
  logic [15:0]      snap_q, snap_d;
  logic [15:0]      field;
  logic [3:0]       nib;
  logic             ref_last;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // Two-flop synchronizer for the asynchronous button
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], btn_next};
  end

  assign btn_sync   = sync_q[1];
  assign db_cnt_inc = db_cnt_q + DB_W'(1);

  // Debounce: one press pulse per stable press, none on hold or bounce
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_state_q <= DB_IDLE;
      db_cnt_q   <= '0;
      press_q    <= 1'b0;
    end else begin
      press_q <= 1'b0;
      case (db_state_q)
        DB_IDLE: begin
          if (btn_sync) begin
            db_state_q <= DB_PRESS_CHK;
            db_cnt_q   <= '0;
          end
        end
        DB_PRESS_CHK: begin
          if (!btn_sync) begin
            db_state_q <= DB_IDLE;
          end else begin
            db_cnt_q <= db_cnt_inc;
            if (db_cnt_inc == DB_LAST) begin
              db_state_q <= DB_HELD;
              press_q    <= 1'b1;
            end
          end
        end
        DB_HELD: begin
          if (!btn_sync) begin
            db_state_q <= DB_REL_CHK;
            db_cnt_q   <= '0;
          end
        end
        DB_REL_CHK: begin
          if (btn_sync) begin
            db_state_q <= DB_HELD;
          end else begin
            db_cnt_q <= db_cnt_inc;
            if (db_cnt_inc == DB_LAST) db_state_q <= DB_IDLE;
          end
        end
        default: db_state_q <= DB_IDLE;
      endcase
    end
  end

  // Scan counters, field select, snapshot and next display outputs
  always_comb begin
    ref_last = (ref_q == REF_LAST);
    ref_d    = ref_last ? '0 : ref_q + REF_W'(1);
    idx_d    = ref_last ? idx_q + 2'd1 : idx_q;

    sel_d = sel_q;
    if (press_q) sel_d = (sel_q == 3'd4) ? 3'd0 : sel_q + 3'd1;

    case (sel_d)
      3'd0:    field = ir_dbg;
      3'd1:    field = {5'b00000, state_dbg, pc_dbg};
      3'd2:    field = rs_val_dbg;
      3'd3:    field = rt_val_dbg;
      default: field = alu_out_dbg;
    endcase

    // Reload at scan start or on a field change so a scan never mixes two values
    snap_d = snap_q;
    if (press_q || (ref_last && idx_q == 2'd3)) snap_d = field;

    nib  = snap_q[{idx_q, 2'b00} +: 4];
    an_d  = ~(4'b0001 << idx_q);
    seg_d = hex7(nib);
    dp_d  = ~(sel_q == 3'd1 && idx_q == 2'd2);
`ifdef DBG_SEG_BLANK_EN
    if (idx_q != 2'd0 && (snap_q >> {idx_q, 2'b00}) == 16'h0000) begin
      an_d  = 4'b1111;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_q  <= '0;
      idx_q  <= 2'd0;
      sel_q  <= 3'd0;
      snap_q <= 16'h0000;
      an_q   <= 4'b1111;
      seg_q  <= 7'h7F;
      dp_q   <= 1'b1;
    end else begin
      ref_q  <= ref_d;
      idx_q  <= idx_d;
      sel_q  <= sel_d;
      snap_q <= snap_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
    end
  end

  assign an      = an_q;
  assign seg     = seg_q;
  assign dp      = dp_q;
  assign sel_dbg = sel_q;

endmodule

// File: tb/tb_dbg_seg_display.sv
// Self-checking bench for dbg_seg_display against a run-length/cycle-count reference model.
module tb_dbg_seg_display;
  localparam int unsigned R = 4;
  localparam int unsigned D = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btn_next = 1'b0;
  logic [2:0]  state_dbg = '0;
  logic [7:0]  pc_dbg = '0;
  logic [15:0] ir_dbg = '0;
  logic [15:0] rs_val_dbg = '0;
  logic [15:0] rt_val_dbg = '0;
  logic [15:0] alu_out_dbg = '0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [2:0]  sel_dbg;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S5 = 7'b0010010, SA = 7'b0001000, SF = 7'b0001110;

  dbg_seg_display #(.REFRESH_DIV(R), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .btn_next(btn_next), .state_dbg(state_dbg), .pc_dbg(pc_dbg),
    .ir_dbg(ir_dbg), .rs_val_dbg(rs_val_dbg), .rt_val_dbg(rt_val_dbg), .alu_out_dbg(alu_out_dbg),
    .seg(seg), .dp(dp), .an(an), .sel_dbg(sel_dbg)
  );

  always #5 clk = ~clk;

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  function automatic logic [15:0] field_of(input int s);
    case (s)
      0:       return ir_dbg;
      1:       return {5'b00000, state_dbg, pc_dbg};
      2:       return rs_val_dbg;
      3:       return rt_val_dbg;
      default: return alu_out_dbg;
    endcase
  endfunction

  // Reference model: time since reset selects the digit, button accepted after D equal samples
  int          t, m_sel, run, idx, rc, nsel, nib;
  bit          held, pulse, s1, s2, samp;
  logic [15:0] snap;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic [2:0]  exp_sel;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      t = 0; m_sel = 0; run = 0; held = 0; pulse = 0; s1 = 0; s2 = 0; snap = '0;
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_sel = 3'd0;
    end else begin
      idx = (t / R) % 4;
      rc  = t % R;
      nib = int'((snap >> (4 * idx)) & 16'h000F);
      exp_an = 4'hF;
      exp_an[idx] = 1'b0;
      exp_seg = hex_tab[nib];
      exp_dp  = !(m_sel == 1 && idx == 2);
`ifdef DBG_SEG_BLANK_EN
      if (idx > 0 && (snap >> (4 * idx)) == 16'h0000) begin
        exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
      end
`endif
      nsel = pulse ? (m_sel + 1) % 5 : m_sel;
      if (pulse || (rc == R - 1 && idx == 3)) snap = field_of(nsel);
      m_sel = nsel;
      exp_sel = 3'(m_sel);
      samp = s2; s2 = s1; s1 = btn_next;
      pulse = 0;
      run = (samp != held) ? run + 1 : 0;
      if (run == D) begin
        pulse = !held;
        held  = !held;
        run   = 0;
      end
      t++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int hi, input int lo);
    btn_next = 1'b1; tick(hi);
    btn_next = 1'b0; tick(lo);
  endtask

  task automatic wait_an(input logic [3:0] pat, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (an === pat) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic randomize_data();
    state_dbg = 3'($urandom); pc_dbg = 8'($urandom); ir_dbg = 16'($urandom);
    rs_val_dbg = 16'($urandom); rt_val_dbg = 16'($urandom); alu_out_dbg = 16'($urandom);
  endtask

  task automatic test_reset();
    logic [3:0] walk;
    reset = 1'b1;
    randomize_data();
    btn_next = 1'($urandom);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, dp, sel_dbg} !== {4'hF, 7'h7F, 1'b1, 3'd0}) begin
        errors++;
        $display("FAIL reset_hold an=%b seg=%h dp=%b sel=%0d, expected an=1111 seg=7f dp=1 sel=0", an, seg, dp, sel_dbg);
      end
    end
    btn_next = 1'b0;
    reset = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      walk = 4'hF;
      walk[k / 4] = 1'b0;
`ifdef DBG_SEG_BLANK_EN
      if (k >= 4) walk = 4'hF;
`endif
      checks++;
      if (an !== walk) begin
        errors++;
        $display("FAIL anode_walk cycle=%0d an=%b expected %b", k, an, walk);
      end
    end
  endtask

  task automatic test_scan();
    bit ok;
    logic [3:0]  pats [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    logic [6:0]  segs [5] = '{S2, S1, S5, S1, SF};
    ir_dbg = 16'h1512;
    tick(20);
    for (int d = 0; d < 5; d++) begin
      wait_an(pats[d], ok);
      checks++;
      if (!ok || seg !== segs[d]) begin
        errors++;
        $display("FAIL scan_digit step=%0d found=%0b an=%b seg=%b expected seg=%b", d, ok, an, seg, segs[d]);
      end
      if (d == 0) ir_dbg = 16'hFFFF;
    end
  endtask

  task automatic test_press();
    bit ok;
    int changes;
    logic [2:0] prev;
    state_dbg = 3'd2; pc_dbg = 8'h03;
    changes = 0;
    prev = sel_dbg;
    for (int k = 0; k < 40; k++) begin
      btn_next = (k < 20);
      @(negedge clk);
      if (sel_dbg !== prev) changes++;
      prev = sel_dbg;
      checks++;
      if ({an, seg, dp, sel_dbg} !== {exp_an, exp_seg, exp_dp, exp_sel}) begin
        errors++;
        $display("FAIL press_model an=%b seg=%b dp=%b sel=%0d expected an=%b seg=%b dp=%b sel=%0d",
                 an, seg, dp, sel_dbg, exp_an, exp_seg, exp_dp, exp_sel);
      end
    end
    checks++;
    if (changes !== 1 || sel_dbg !== 3'd1) begin
      errors++;
      $display("FAIL single_press changes=%0d sel=%0d expected changes=1 sel=1", changes, sel_dbg);
    end
    wait_an(4'b1110, ok);
    checks++;
    if (!ok || seg !== S3 || dp !== 1'b1) begin
      errors++;
      $display("FAIL pc_digit0 an=%b seg=%b dp=%b expected seg=%b dp=1", an, seg, dp, S3);
    end
    wait_an(4'b1101, ok);
    checks++;
    if (!ok || seg !== S0 || dp !== 1'b1) begin
      errors++;
      $display("FAIL pc_digit1 an=%b seg=%b dp=%b expected seg=%b dp=1", an, seg, dp, S0);
    end
    wait_an(4'b1011, ok);
    checks++;
    if (!ok || seg !== S2 || dp !== 1'b0) begin
      errors++;
      $display("FAIL state_digit2 an=%b seg=%b dp=%b expected seg=%b dp=0", an, seg, dp, S2);
    end
  endtask

  task automatic test_bounce();
    logic [2:0] seq [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    for (int k = 0; k < 50; k++) begin
      btn_next = (k < 30) ? 1'((k / 3) % 2 == 0) : 1'b0;
      @(negedge clk);
      checks++;
      if ({an, seg, dp, sel_dbg} !== {exp_an, exp_seg, exp_dp, exp_sel}) begin
        errors++;
        $display("FAIL bounce_model an=%b seg=%b dp=%b sel=%0d expected an=%b seg=%b dp=%b sel=%0d",
                 an, seg, dp, sel_dbg, exp_an, exp_seg, exp_dp, exp_sel);
      end
    end
    checks++;
    if (sel_dbg !== 3'd1) begin
      errors++;
      $display("FAIL bounce_sel sel=%0d expected 1", sel_dbg);
    end
    reset = 1'b1; tick(2); reset = 1'b0;
    for (int p = 0; p < 5; p++) begin
      press(15, 15);
      checks++;
      if (sel_dbg !== seq[p] || sel_dbg !== exp_sel) begin
        errors++;
        $display("FAIL press_seq n=%0d sel=%0d expected %0d", p, sel_dbg, seq[p]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    press(15, 15);
    btn_next = 1'b1;
    tick(8);
    #2 reset = 1'b1; btn_next = 1'b0;
    #1;
    checks++;
    if ({an, seg, dp, sel_dbg} !== {4'hF, 7'h7F, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL async_reset_db an=%b seg=%h dp=%b sel=%0d expected an=1111 seg=7f dp=1 sel=0", an, seg, dp, sel_dbg);
    end
    @(negedge clk);
    reset = 1'b0;
    ir_dbg = 16'hFFFF;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, dp, sel_dbg} !== {exp_an, exp_seg, exp_dp, exp_sel} || sel_dbg !== 3'd0) begin
        errors++;
        $display("FAIL no_ghost_press an=%b seg=%b dp=%b sel=%0d expected an=%b seg=%b dp=%b sel=0",
                 an, seg, dp, sel_dbg, exp_an, exp_seg, exp_dp);
      end
    end
    wait_an(4'b1011, ok);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (!ok || {an, seg, dp, sel_dbg} !== {4'hF, 7'h7F, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL async_reset_scan found=%0b an=%b seg=%h dp=%b sel=%0d expected an=1111 seg=7f dp=1 sel=0",
               ok, an, seg, dp, sel_dbg);
    end
    @(negedge clk);
    reset = 1'b0;
    tick(4);
  endtask

  task automatic test_blank();
    reset = 1'b1; tick(2); reset = 1'b0;
    repeat (4) press(15, 15);
    checks++;
    if (sel_dbg !== 3'd4) begin
      errors++;
      $display("FAIL sel_to_alu sel=%0d expected 4", sel_dbg);
    end
    alu_out_dbg = 16'h003A;
    tick(20);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, dp, sel_dbg} !== {exp_an, exp_seg, exp_dp, exp_sel}) begin
        errors++;
        $display("FAIL blank_model an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b", an, seg, dp, exp_an, exp_seg, exp_dp);
      end
      checks++;
`ifdef DBG_SEG_BLANK_EN
      if (an[3] !== 1'b1 || an[2] !== 1'b1 || (an === 4'b1110 && seg !== SA) || (an === 4'b1101 && seg !== S3)) begin
`else
      if (((an === 4'b0111 || an === 4'b1011) && seg !== S0) || (an === 4'b1110 && seg !== SA) || (an === 4'b1101 && seg !== S3)) begin
`endif
        errors++;
        $display("FAIL alu_003a an=%b seg=%b", an, seg);
      end
    end
    alu_out_dbg = 16'h0000;
    tick(20);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checks++;
`ifdef DBG_SEG_BLANK_EN
      if (!(an === 4'b1110 || an === 4'b1111) || (an === 4'b1110 && seg !== S0)) begin
`else
      if (seg !== S0 || an === 4'b1111) begin
`endif
        errors++;
        $display("FAIL alu_zero an=%b seg=%b", an, seg);
      end
    end
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    for (int k = 0; k < 1200; k++) begin
      if (hold == 0) begin
        btn_next = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 20);
      end
      hold--;
      randomize_data();
      reset = ($urandom_range(0, 299) == 0);
      @(negedge clk);
      checks++;
      if ({an, seg, dp, sel_dbg} !== {exp_an, exp_seg, exp_dp, exp_sel}) begin
        errors++;
        $display("FAIL random_model cycle=%0d an=%b seg=%b dp=%b sel=%0d expected an=%b seg=%b dp=%b sel=%0d",
                 k, an, seg, dp, sel_dbg, exp_an, exp_seg, exp_dp, exp_sel);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_press();
    test_bounce();
    test_reset_mid();
    test_blank();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dbg_seg_display.md
Name: dbg_seg_display

Overview:
- Downstream consumer of the CPU core's debug outputs (state, PC, IR, register-read values, ALU output).
- Drives the Basys 3 4-digit 7-segment display with one selectable 16-bit debug field, shown in hex.
- A debounced push-button steps through the fields.
- Sits in the board top level beside the CPU core; it has no effect on CPU state.

Parameters:
- REFRESH_DIV, 100000, clock cycles each digit is lit (1 kHz digit rate at 100 MHz); minimum 2.
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronized samples required before a button level change is accepted; minimum 2.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous active-high reset
- btn_next  in  1  raw push-button, active-high, asynchronous to clk
- state_dbg  in  3  CPU FSM state
- pc_dbg  in  8  CPU program counter
- ir_dbg  in  16  CPU instruction register
- rs_val_dbg  in  16  CPU rs read data
- rt_val_dbg  in  16  CPU rt read data
- alu_out_dbg  in  16  CPU ALU output register
- seg  out  7  cathodes, active-low, seg[6:0]=g,f,e,d,c,b,a
- dp  out  1  decimal point, active-low
- an  out  4  anodes, active-low, an[0]=rightmost digit
- sel_dbg  out  3  currently selected field (for LEDs)

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-high. While reset is asserted:
  - an=4'b1111, seg=7'h7F, dp=1, sel_dbg=0.
  - Refresh counter, digit index and snapshot are 0; the debounce FSM is in DB_IDLE.
  - Reset asserted mid-operation behaves identically; no pending press survives it.
- Field select (sel): 0=ir_dbg, 1={5'b0,state_dbg,pc_dbg}, 2=rs_val_dbg, 3=rt_val_dbg, 4=alu_out_dbg.
  - Each accepted press increments sel; 4 wraps to 0.
  - Values 5-7 never occur.
- Button path:
  - Two-flop synchronizer, then the debounce FSM with a counter sized for DEBOUNCE_CYCLES.
  - DB_IDLE: sync=1 → DB_PRESS_CHK with counter cleared.
  - DB_PRESS_CHK: sync=0 → DB_IDLE. Otherwise count; when counter reaches DEBOUNCE_CYCLES-1 → DB_HELD and emit a one-cycle press pulse.
  - DB_HELD: sync=0 → DB_REL_CHK with counter cleared.
  - DB_REL_CHK: sync=1 → DB_HELD with no pulse. When counter reaches DEBOUNCE_CYCLES-1 → DB_IDLE.
  - Consequence: exactly one pulse per stable press; holding the button does not auto-repeat.
  - sel updates on the clock after the pulse.
- Scan:
  - Refresh counter counts 0..REFRESH_DIV-1 and wraps. At terminal count the 2-bit digit index increments (3 wraps to 0).
- Snapshot (16-bit), loaded from the selected field:
  - when the refresh counter is at terminal and the digit index is 3 (start of a new scan), and
  - on the cycle sel changes, so the new field appears within one scan.
  - The displayed value therefore never tears within a scan. Input changes between snapshots are not shown.
- Output register, updated every cycle from the current digit index and snapshot (1 cycle latency):
  - an = one-hot-low of the digit index.
  - seg = hex decode of snapshot nibble [4*idx+3 : 4*idx]. Examples: 0→1000000, 1→1111001, 8→0000000, A→0001000, F→0001110.
  - dp = 0 only when sel=1 and idx=2 (separates state from PC); otherwise 1.
- Arithmetic: all counters unsigned, wrap silently; no saturation.

Optional Feature:
- Macro: DBG_SEG_BLANK_EN.
- Defined: leading-zero blanking.
  - Digit idx>0 is blanked (an all 1s, seg=7'h7F) when every snapshot nibble from idx up to 3 is zero.
  - Digit 0 is always shown, so a value of 0 displays "0".
  - dp follows its normal rule, but is forced to 1 on a blanked digit.
- Not defined: all four digits are always lit, including leading zeros.

Test Plan (bench uses REFRESH_DIV=4, DEBOUNCE_CYCLES=8):
1. Reset held 5 cycles with arbitrary inputs → an=1111, seg=7F, dp=1, sel_dbg=0. After release, an walks 1110→1101→1011→0111, changing every 4 cycles.
2. ir_dbg=16'h1512, sel=0, run one full scan → digit 0 seg=0100100 ("2"), digit 1 "1", digit 2 "5", digit 3 "1". Change ir_dbg mid-scan → display unchanged until the next scan start.
3. btn_next high for 20 cycles, then low for 20 → exactly one pulse; sel_dbg goes 0→1. With state_dbg=3'd2 and pc_dbg=8'h03, the display reads "0203" with dp low on digit 2 only.
4. Bounce: btn_next toggles every 3 cycles for 30 cycles, then settles low → sel_dbg unchanged. Five clean presses from sel 0 → sequence 1,2,3,4,0.
5. Assert reset while in DB_PRESS_CHK (counter=5) and again during the third digit of a scan → all outputs return to reset values immediately, without waiting for a clock edge, and no press pulse is generated after release.
6. With DBG_SEG_BLANK_EN defined, alu_out_dbg=16'h003A, sel=4 → digits 3 and 2 are dark (an bits high), digits 1:0 show "3A". With alu_out_dbg=0, only digit 0 lights, showing "0".
